sub_bytes_iter: RTL and testbench
=================================

# sub_bytes_iter

Parametrised, sequential AES SubBytes/InvSubBytes engine for the 128-bit state. It processes `LANES` bytes per cycle and takes 16/`LANES` cycles per block, so area can be traded for latency. It adds a per-block forward/inverse mode and valid/ready handshakes on both sides. It sits between the round-key/ShiftRows stages of the AES round datapath in the Blowfish/AES hybrid core, replacing the fully combinational 16-S-box SubBytes where area matters.

## Interface
- `LANES`, default 4: S-box instances, i.e. bytes per cycle. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- `NCHUNK`, derived as 16/`LANES`, not overridable: cycles per block.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_data` and `in_inv` are valid.
- `in_ready` output 1: engine can accept a block.
- `in_data` input 128: state. Byte 0 is `[127:120]`; byte 15 is `[7:0]`.
- `in_inv` input 1: 0 selects SubBytes, 1 selects InvSubBytes. Sampled with the block.
- `out_valid` output 1: `out_data` holds a finished block.
- `out_ready` input 1: downstream accepts `out_data`.
- `out_data` output 128: substituted state, same byte order as `in_data`.
- `busy` output 1: a block is in progress or waiting to be accepted.

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: load `in_data` into working register `st`, latch `in_inv` into `mode`, set `cnt`=0, go to RUN.
- RUN, each cycle:
  - Chunk `cnt` (bytes `cnt*LANES` .. `cnt*LANES+LANES-1`, MSB-first) of `st` is replaced by the S-box (or inverse S-box, per `mode`) of those bytes. All other bytes hold.
  - `cnt` increments.
  - When `cnt`==`NCHUNK`-1 is processed, go to HOLD.
  - For `LANES`=16, RUN lasts exactly one cycle.
- HOLD:
  - `out_valid`=1 and `out_data`=`st`.
  - `out_data` stays stable while `out_valid`&&!`out_ready`.
  - On `out_ready`: go to IDLE.
- `in_ready`=(state==IDLE). Inputs offered in RUN/HOLD are ignored; the source must hold them.
- `busy`=(state!=IDLE).
- `out_data` is `st` in every state. It is only meaningful when `out_valid`=1.
- `cnt` width is clog2(`NCHUNK`), minimum 1 bit. `cnt` wraps to 0 on entry to HOLD.
- `mode` cannot change mid-block.
- Reset (asynchronous, any state, including mid-RUN):
  - Next state IDLE; `st`=0, `cnt`=0, `mode`=0.
  - The partial block is discarded and never presented.
  - Reset output values: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0.

## Timing
- Accept edge at E0.
- `out_valid` rises after edge E0+`NCHUNK`: for `LANES`=4, 4 cycles after acceptance; for `LANES`=1, 16; for `LANES`=16, 1.
- With `out_ready` held high, HOLD lasts 1 cycle. IDLE then lasts at least 1 cycle.
- Peak throughput: one block per `NCHUNK`+2 cycles.
- No combinational path from `in_valid` to `in_ready` or `out_valid`, or from `out_ready` to `out_valid` or `in_ready`. All outputs come from registers or decode of the registered state.
- S-box lookup sits in one cycle: the ROM plus mux feeds `st` directly, with no internal pipeline.

## Structure
- Shared package `aes_pkg`:
  - 256×8 constants `SBOX_FWD` and `SBOX_INV`.
  - State enum `sb_state_t` {IDLE, RUN, HOLD}.
  - Function `legal_lanes(int)`.
- Sub-module `sbox_fi`: 8-bit in, 1-bit inv, 8-bit out, combinational lookup into both tables. Instantiated `LANES` times in a generate loop, fed by a chunk mux on `cnt`.

## Test plan
- FIPS-197 App. B, `LANES`=4, forward:
  - Stimulus: `in_data`=193de3bea0f4e22b9ac68d2ae9f84808.
  - Response: `out_data`=d42711aee0bf98f1b8b45de51e415230, with `out_valid` rising exactly 4 cycles after acceptance.
- Inverse round-trip, `LANES`=16, `in_inv`=1:
  - Stimulus: d42711aee0bf98f1b8b45de51e415230.
  - Response: 193de3bea0f4e22b9ac68d2ae9f84808, 1 cycle after acceptance.
- All-zero block, `LANES`=1:
  - Stimulus: all-zero `in_data`.
  - Response: all bytes 63, after 16 cycles. Mid-run snapshots show bytes 0..k equal to 63 and the rest 00.
- Backpressure:
  - Stimulus: `out_ready`=0 for 10 cycles in HOLD.
  - Response: `out_valid` and `out_data` stable, `in_ready`=0, and a new `in_valid` is ignored. `out_ready`=1 then returns to IDLE with `in_ready`=1 the next cycle.
- Reset mid-RUN:
  - Stimulus: `rst_n` pulled low at `cnt`=2 (`LANES`=4).
  - Response: `out_valid`=0, `out_data`=0, `in_ready`=1 immediately. The next block (53 repeated, forward) gives ED repeated with normal latency.
- Back-to-back mixed modes:
  - Stimulus: forward block 00..0F, then inverse of its result, `out_ready` tied high.
  - Response: the second output equals 000102…0F, with spacing `NCHUNK`+2 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: forward/inverse S-box tables, the iterative
// SubBytes FSM state type and a LANES legality helper.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sb_state_t;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic bit legal_lanes(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

endpackage

// File: rtl/sbox_fi.sv
// Combinational forward/inverse AES S-box lookup for one byte.
// Ports: data_i byte in, inv_i selects inverse table, data_o byte out.
module sbox_fi
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       inv_i,
    output logic [7:0] data_o
);

    assign data_o = inv_i ? SBOX_INV[data_i] : SBOX_FWD[data_i];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes/InvSubBytes: LANES bytes per cycle, 16/LANES
// cycles per block. Ports: clk, rst_n (async, active-low); input side
// in_valid/in_ready/in_data/in_inv; output side out_valid/out_ready/
// out_data; busy while a block is in flight or awaiting acceptance.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NCHUNK = 16 / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!legal_lanes(LANES)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_t       state_q, state_d;
    logic [127:0]    st_q, st_d, st_upd;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            last_chunk;
    logic [7:0]      st_b     [16];
    logic [7:0]      lane_in  [LANES];
    logic [7:0]      lane_out [LANES];

    // Byte i belongs to chunk i/LANES and is served by lane i%LANES.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int CHUNK = i / LANES;
        localparam int LANE  = i % LANES;
        assign st_b[i] = st_q[127-8*i -: 8];
        assign st_upd[127-8*i -: 8] =
            (cnt_q == CW'(CHUNK)) ? lane_out[LANE] : st_b[i];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [3:0] idx;
        assign idx         = 4'(int'(cnt_q) * LANES + g);
        assign lane_in[g]  = st_b[idx];
        sbox_fi u_sbox (
            .data_i (lane_in[g]),
            .inv_i  (mode_q),
            .data_o (lane_out[g])
        );
    end

    assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_data;
                    mode_d  = in_inv;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                st_d = st_upd;
                if (last_chunk) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = st_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter with LANES = 4, 16 and 1.
// The S-box model is derived from GF(2^8) arithmetic inside the bench.
module tb_sub_bytes_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         in_inv    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    sub_bytes_iter #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_inv(in_inv[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0])
    );

    sub_bytes_iter #(.LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_inv(in_inv[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1])
    );

    sub_bytes_iter #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_inv(in_inv[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .busy(busy[2])
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mfwd [256];
    logic [7:0] minv [256];

    function automatic int nchunk(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    task automatic build_model();
        logic [7:0] v, s;
        for (int x = 0; x < 256; x++) begin
            v = ginv(8'(x));
            s = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3)
                  ^ rotl8(v, 4) ^ 8'h63;
            mfwd[x] = s;
            minv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_sb(input logic [127:0] blk,
                                              input logic inv);
        logic [127:0] r = '0;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b   = blk[127:120];
            blk = blk << 8;
            r   = {r[119:0], inv ? minv[b] : mfwd[b]};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Per-DUT scoreboard: at most one block is ever in flight.
    logic         pending  [3];
    logic [127:0] exp_data [3];
    int           acc      [3];
    logic         prev_ov  [3];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                pending[d] = 1'b0;
                prev_ov[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("ready_vs_busy dut%0d", d),
                      128'(in_ready[d]), 128'(!busy[d]));
                if (out_valid[d]) begin
                    if (!pending[d]) begin
                        checks++;
                        fails++;
                        $display("FAIL spurious_out dut%0d: out_valid=1 required 0", d);
                    end else begin
                        check($sformatf("out_data dut%0d", d),
                              out_data[d], exp_data[d]);
                        if (!prev_ov[d])
                            check($sformatf("latency dut%0d", d),
                                  128'(cyc - acc[d]), 128'(nchunk(d)));
                    end
                    if (out_ready[d]) pending[d] = 1'b0;
                end
                if (in_valid[d] && in_ready[d]) begin
                    pending[d]  = 1'b1;
                    exp_data[d] = model_sb(in_data[d], in_inv[d]);
                    acc[d]      = cyc + 1;
                end
                prev_ov[d] = out_valid[d];
            end
        end
    end

    task automatic send(input int d, input logic [127:0] data,
                        input logic inv, output int a);
        int n = 0;
        @(posedge clk);
        #1;
        in_data[d]  = data;
        in_inv[d]   = inv;
        in_valid[d] = 1'b1;
        @(negedge clk);
        while (!in_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            checks++;
            fails++;
            $display("FAIL send_timeout dut%0d: in_ready=0 required 1", d);
        end
        a = cyc + 1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, output int t);
        int n = 0;
        t = -1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid[d]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            checks++;
            fails++;
            $display("FAIL out_timeout dut%0d: out_valid=0 required 1", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a2, t;
        logic [127:0] e, r1;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_inv[d]    = 1'b0;
            out_ready[d] = 1'b1;
        end
        build_model();

        check("model_fwd_00", 128'(mfwd[8'h00]), 128'h63);
        check("model_fwd_53", 128'(mfwd[8'h53]), 128'hed);
        check("model_fwd_ff", 128'(mfwd[8'hff]), 128'h16);
        check("model_inv_63", 128'(minv[8'h63]), 128'h00);
        check("model_fips",
              model_sb(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0),
              128'hd42711aee0bf98f1b8b45de51e415230);

        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_in_ready dut%0d", d), 128'(in_ready[d]), 128'd1);
            check($sformatf("rst_out_valid dut%0d", d), 128'(out_valid[d]), 128'd0);
            check($sformatf("rst_busy dut%0d", d), 128'(busy[d]), 128'd0);
            check($sformatf("rst_out_data dut%0d", d), out_data[d], 128'd0);
        end
        #1 rst_n = 1'b1;

        // FIPS-197 App. B, LANES=4 forward
        send(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, a);
        wait_out(0, t);
        check("fips_data", out_data[0], 128'hd42711aee0bf98f1b8b45de51e415230);
        check("fips_latency", 128'(t - a), 128'd4);

        // Inverse, LANES=16
        send(1, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, a);
        wait_out(1, t);
        check("inv16_data", out_data[1], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        check("inv16_latency", 128'(t - a), 128'd1);

        // All-zero, LANES=1, with mid-run snapshots
        send(2, 128'd0, 1'b0, a);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            e = '0;
            for (int j = 0; j < 16; j++)
                e = {e[119:0], (j < k) ? 8'h63 : 8'h00};
            check($sformatf("snap_k%0d", k), out_data[2], e);
        end
        wait_out(2, t);
        check("zero_data", out_data[2], {16{8'h63}});
        check("zero_latency", 128'(t - a), 128'd16);

        // Backpressure on LANES=4
        out_ready[0] = 1'b0;
        send(0, 128'h00112233445566778899aabbccddeeff, 1'b0, a);
        wait_out(0, t);
        #1;
        in_data[0]  = 128'hffeeddccbbaa99887766554433221100;
        in_inv[0]   = 1'b1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 128'(out_valid[0]), 128'd1);
            check("bp_in_ready", 128'(in_ready[0]), 128'd0);
            check("bp_data", out_data[0],
                  model_sb(128'h00112233445566778899aabbccddeeff, 1'b0));
            @(negedge clk);
            #1;
        end
        in_valid[0]  = 1'b0;
        in_inv[0]    = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_in_ready", 128'(in_ready[0]), 128'd1);
        check("bp_release_out_valid", 128'(out_valid[0]), 128'd0);

        // Reset mid-RUN at cnt=2
        send(0, 128'h0123456789abcdeffedcba9876543210, 1'b0, a);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 128'(out_valid[0]), 128'd0);
        check("mrst_out_data", out_data[0], 128'd0);
        check("mrst_in_ready", 128'(in_ready[0]), 128'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(0, {16{8'h53}}, 1'b0, a);
        wait_out(0, t);
        check("post_rst_data", out_data[0], {16{8'hed}});
        check("post_rst_latency", 128'(t - a), 128'd4);

        // Back-to-back forward then inverse
        send(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, a);
        r1 = model_sb(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        send(0, r1, 1'b1, a2);
        check("b2b_spacing", 128'(a2 - a), 128'd6);
        wait_out(0, t);
        check("b2b_roundtrip", out_data[0], 128'h000102030405060708090a0b0c0d0e0f);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
